se_sram_srw_arbiter_2p: RTL and testbench

- Shares one single-port synchronous SRAM (se_sram_srw_we-style: select, read_not_write, per-byte write_enable, one-cycle read latency) between two requesters, e.g. CPU and DMA.
- Optionally clears the whole array after reset.
- Arbitrates per cycle with round-robin fairness and returns read data with a valid strobe to the requester that issued the read.
- Sits directly in front of an se_sram_srw_* instance, on the same clock.

---
 rtl/se_sram_srw_arbiter_2p_pkg.sv | 22 ++
 rtl/se_sram_srw_arbiter_2p_rr_arb.sv | 38 +++
 rtl/se_sram_srw_arbiter_2p.sv | 152 +++++++++++++++
 tb/tb_se_sram_srw_arbiter_2p.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/se_sram_srw_arbiter_2p_pkg.sv
// Shared types for the two-port SRAM arbiter: controller state encoding and
// the requester-index type that names port 0 and port 1.
package se_sram_srw_arbiter_2p_pkg;

    // Controller state: sweep-clear the array, then serve requests.
    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } arb_state_e;

    // Which requester a grant or read response belongs to.
    typedef logic req_idx_t;

    localparam req_idx_t ReqIdx0 = 1'b0;
    localparam req_idx_t ReqIdx1 = 1'b1;

    // Round-robin pick for a two-way conflict: the side that did not win last.
    function automatic req_idx_t rr_other(input req_idx_t last);
        return (last == ReqIdx0) ? ReqIdx1 : ReqIdx0;
    endfunction

endpackage

// File: rtl/se_sram_srw_arbiter_2p_rr_arb.sv
// Two-input round-robin arbiter. The grant is combinational; the last winner
// is remembered so that simultaneous requests alternate between the inputs.
module se_sram_srw_arbiter_2p_rr_arb
    import se_sram_srw_arbiter_2p_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_enable,
    input  logic     i_req0,
    input  logic     i_req1,
    output logic     o_grant_valid,
    output req_idx_t o_grant_idx
);

    req_idx_t r_last_grant;

    // Pick a winner this cycle; on a conflict the previous loser goes first.
    always_comb begin
        o_grant_valid = i_req0 | i_req1;
        o_grant_idx   = ReqIdx0;
        if (i_req0 && i_req1) begin
            o_grant_idx = rr_other(r_last_grant);
        end else if (i_req1) begin
            o_grant_idx = ReqIdx1;
        end
    end

    // Remember the winner of every enabled, granted cycle. Resetting to port 1
    // makes port 0 win the first conflict.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last_grant <= ReqIdx1;
        end else if (i_enable && o_grant_valid) begin
            r_last_grant <= o_grant_idx;
        end
    end

endmodule

// File: rtl/se_sram_srw_arbiter_2p.sv
// Two-requester front end for a single-port synchronous SRAM. Optionally
// zeroes the whole array after reset, then arbitrates one access per enabled
// cycle round-robin and routes the one-cycle-latency read data back to the
// requester that issued the read.
module se_sram_srw_arbiter_2p
    import se_sram_srw_arbiter_2p_pkg::*;
#(
    parameter int unsigned address_width  = 15,
    parameter int unsigned data_width     = 32,
    parameter int unsigned we_width       = 4,
    parameter bit          clear_on_reset = 1'b1
) (
    input  logic                     sram_clock,
    input  logic                     sram_clock__enable,
    input  logic                     reset,

    input  logic                     req0_valid,
    input  logic                     req0_read_not_write,
    input  logic [address_width-1:0] req0_address,
    input  logic [data_width-1:0]    req0_write_data,
    input  logic [we_width-1:0]      req0_byte_enable,
    output logic                     req0_ack,
    output logic                     resp0_valid,
    output logic [data_width-1:0]    resp0_data,

    input  logic                     req1_valid,
    input  logic                     req1_read_not_write,
    input  logic [address_width-1:0] req1_address,
    input  logic [data_width-1:0]    req1_write_data,
    input  logic [we_width-1:0]      req1_byte_enable,
    output logic                     req1_ack,
    output logic                     resp1_valid,
    output logic [data_width-1:0]    resp1_data,

    output logic                     sram_select,
    output logic                     sram_read_not_write,
    output logic [we_width-1:0]      sram_write_enable,
    output logic [address_width-1:0] sram_address,
    output logic [data_width-1:0]    sram_write_data,
    input  logic [data_width-1:0]    sram_data_out,

    output logic                     init_done
);

    localparam logic [address_width-1:0] AddrLast = {address_width{1'b1}};
    localparam logic [address_width-1:0] AddrOne  = {{(address_width-1){1'b0}}, 1'b1};
    localparam logic [we_width-1:0]      WeAll    = {we_width{1'b1}};

    arb_state_e               r_state;
    logic [address_width-1:0] r_clear_addr;
    logic                     r_rd_pending;
    req_idx_t                 r_rd_owner;

    logic                     w_run;
    logic                     w_clearing;
    logic                     w_grant_valid;
    req_idx_t                 w_grant_idx;
    logic                     w_ack_any;
    logic                     w_read_ack;
    logic                     w_sel_rnw;
    logic [address_width-1:0] w_sel_addr;
    logic [data_width-1:0]    w_sel_wdata;
    logic [we_width-1:0]      w_sel_be;

    // Outputs are forced quiet while reset is held, even though the state
    // register already sits in its reset value.
    always_comb begin
        w_run      = (r_state == StRun) && !reset;
        w_clearing = (r_state == StClear) && !reset;
    end

    se_sram_srw_arbiter_2p_rr_arb u_rr_arb (
        .i_clk         (sram_clock),
        .i_rst         (reset),
        .i_enable      (sram_clock__enable),
        .i_req0        (req0_valid && w_run),
        .i_req1        (req1_valid && w_run),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    // Ack the winner only in enabled cycles and select its request fields.
    always_comb begin
        w_ack_any = w_grant_valid && sram_clock__enable;
        req0_ack  = w_ack_any && (w_grant_idx == ReqIdx0);
        req1_ack  = w_ack_any && (w_grant_idx == ReqIdx1);
        if (w_grant_idx == ReqIdx1) begin
            w_sel_rnw   = req1_read_not_write;
            w_sel_addr  = req1_address;
            w_sel_wdata = req1_write_data;
            w_sel_be    = req1_byte_enable;
        end else begin
            w_sel_rnw   = req0_read_not_write;
            w_sel_addr  = req0_address;
            w_sel_wdata = req0_write_data;
            w_sel_be    = req0_byte_enable;
        end
        w_read_ack = w_ack_any && w_sel_rnw;
    end

    // Drive the SRAM pins from the clear sweep or from the acked request.
    always_comb begin
        sram_select         = 1'b0;
        sram_read_not_write = 1'b0;
        sram_write_enable   = '0;
        sram_address        = '0;
        sram_write_data     = '0;
        if (w_clearing && sram_clock__enable) begin
            sram_select       = 1'b1;
            sram_write_enable = WeAll;
            sram_address      = r_clear_addr;
        end else if (w_ack_any) begin
            sram_select         = 1'b1;
            sram_read_not_write = w_sel_rnw;
            sram_write_enable   = w_sel_rnw ? '0 : w_sel_be;
            sram_address        = w_sel_addr;
            sram_write_data     = w_sel_wdata;
        end
    end

    // Route a pending read response to its owner on the next enabled cycle.
    always_comb begin
        resp0_valid = r_rd_pending && sram_clock__enable && !reset && (r_rd_owner == ReqIdx0);
        resp1_valid = r_rd_pending && sram_clock__enable && !reset && (r_rd_owner == ReqIdx1);
        resp0_data  = sram_data_out;
        resp1_data  = sram_data_out;
        init_done   = w_run;
    end

    // Controller state: clear sweep, then track the single outstanding read.
    always_ff @(posedge sram_clock or posedge reset) begin
        if (reset) begin
            r_state      <= clear_on_reset ? StClear : StRun;
            r_clear_addr <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= ReqIdx0;
        end else if (sram_clock__enable) begin
            if (r_state == StClear) begin
                r_clear_addr <= r_clear_addr + AddrOne;
                if (r_clear_addr == AddrLast) begin
                    r_state <= StRun;
                end
            end
            // A response is consumed every enabled cycle; a new read re-arms it.
            r_rd_pending <= w_read_ack;
            if (w_read_ack) begin
                r_rd_owner <= w_grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_se_sram_srw_arbiter_2p.sv
// Self-checking bench for se_sram_srw_arbiter_2p with a behavioural SRAM and
// a transaction-level reference model (grant rule, word memory, read queue).
module tb_se_sram_srw_arbiter_2p;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int WEW   = 4;
    localparam int LANE  = DW / WEW;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          en = 1'b1;
    logic          reset = 1'b1;
    logic          r0v = 1'b0, r0rnw = 1'b0, r1v = 1'b0, r1rnw = 1'b0;
    logic [AW-1:0] r0a = '0, r1a = '0;
    logic [DW-1:0] r0d = '0, r1d = '0;
    logic [WEW-1:0] r0be = '0, r1be = '0;
    logic          req0_ack, req1_ack, resp0_valid, resp1_valid;
    logic [DW-1:0] resp0_data, resp1_data;
    logic          sram_select, sram_rnw, init_done;
    logic [WEW-1:0] sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata, sram_q;

    logic [DW-1:0] sram_mem [DEPTH];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit            m_run;
    int            m_clear_cnt;
    int            m_last;
    logic [DW-1:0] m_resp_q [$];
    int            m_owner_q [$];
    int            m_gnt;

    // Observations from the most recent cycle
    logic          obs_ack0, obs_ack1, obs_rv0, obs_rv1, obs_init;
    logic [DW-1:0] obs_rd0;
    logic [AW-1:0] obs_addr;

    always #5 clk = ~clk;

    se_sram_srw_arbiter_2p #(
        .address_width  (AW),
        .data_width     (DW),
        .we_width       (WEW),
        .clear_on_reset (1'b1)
    ) dut (
        .sram_clock          (clk),
        .sram_clock__enable  (en),
        .reset               (reset),
        .req0_valid          (r0v),
        .req0_read_not_write (r0rnw),
        .req0_address        (r0a),
        .req0_write_data     (r0d),
        .req0_byte_enable    (r0be),
        .req0_ack            (req0_ack),
        .resp0_valid         (resp0_valid),
        .resp0_data          (resp0_data),
        .req1_valid          (r1v),
        .req1_read_not_write (r1rnw),
        .req1_address        (r1a),
        .req1_write_data     (r1d),
        .req1_byte_enable    (r1be),
        .req1_ack            (req1_ack),
        .resp1_valid         (resp1_valid),
        .resp1_data          (resp1_data),
        .sram_select         (sram_select),
        .sram_read_not_write (sram_rnw),
        .sram_write_enable   (sram_we),
        .sram_address        (sram_addr),
        .sram_write_data     (sram_wdata),
        .sram_data_out       (sram_q),
        .init_done           (init_done)
    );

    // Behavioural single-port SRAM: byte-lane writes, one-cycle read latency.
    always @(posedge clk) begin
        if (en && sram_select) begin
            if (sram_rnw) begin
                sram_q <= sram_mem[sram_addr];
            end else begin
                for (int l = 0; l < WEW; l++) begin
                    if (sram_we[l]) sram_mem[sram_addr][l*LANE +: LANE] <= sram_wdata[l*LANE +: LANE];
                end
            end
        end
    end

    task automatic model_reset();
        m_run = 1'b0;
        m_clear_cnt = 0;
        m_last = 1;
        m_resp_q.delete();
        m_owner_q.delete();
    endtask

    // One clock cycle: predict, compare mid-cycle, advance the model.
    task automatic cycle();
        int g;
        bit rnw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [WEW-1:0] be;
        bit ev0, ev1, exp_sel;
        @(negedge clk);
        g = -1;
        if (m_run && en) begin
            if (r0v && r1v) g = (m_last == 0) ? 1 : 0;
            else if (r0v) g = 0;
            else if (r1v) g = 1;
        end
        rnw = (g == 1) ? r1rnw : r0rnw;
        a   = (g == 1) ? r1a : r0a;
        wd  = (g == 1) ? r1d : r0d;
        be  = (g == 1) ? r1be : r0be;
        ev0 = en && m_owner_q.size() > 0 && m_owner_q[0] == 0;
        ev1 = en && m_owner_q.size() > 0 && m_owner_q[0] == 1;

        obs_ack0 = req0_ack; obs_ack1 = req1_ack; obs_rv0 = resp0_valid;
        obs_rv1 = resp1_valid; obs_rd0 = resp0_data; obs_init = init_done;
        obs_addr = sram_addr;

        n_checks++;
        if (req0_ack !== (g == 0) || req1_ack !== (g == 1)) begin
            n_fail++;
            $display("FAIL ack: got %b%b expected %b%b", req0_ack, req1_ack, g == 0, g == 1);
        end
        n_checks++;
        if (resp0_valid !== ev0 || resp1_valid !== ev1) begin
            n_fail++;
            $display("FAIL resp_valid: got %b%b expected %b%b", resp0_valid, resp1_valid, ev0, ev1);
        end
        if (ev0 || ev1) begin
            n_checks++;
            if ((ev0 ? resp0_data : resp1_data) !== m_resp_q[0]) begin
                n_fail++;
                $display("FAIL resp_data: got %h expected %h", ev0 ? resp0_data : resp1_data,
                         m_resp_q[0]);
            end
        end
        n_checks++;
        if (init_done !== m_run) begin
            n_fail++;
            $display("FAIL init_done: got %b expected %b", init_done, m_run);
        end
        exp_sel = m_run ? (g >= 0) : en;
        n_checks++;
        if (sram_select !== exp_sel) begin
            n_fail++;
            $display("FAIL sram_select: got %b expected %b", sram_select, exp_sel);
        end else if (!m_run && en) begin
            n_checks++;
            if (sram_addr !== AW'(m_clear_cnt) || sram_rnw !== 1'b0 || sram_we !== '1 ||
                sram_wdata !== '0) begin
                n_fail++;
                $display("FAIL clear_pins: got a=%h rnw=%b we=%h d=%h expected a=%h rnw=0 we=f d=0",
                         sram_addr, sram_rnw, sram_we, sram_wdata, AW'(m_clear_cnt));
            end
        end else if (g >= 0) begin
            n_checks++;
            if (sram_addr !== a || sram_rnw !== rnw || sram_we !== (rnw ? '0 : be) ||
                (!rnw && sram_wdata !== wd)) begin
                n_fail++;
                $display("FAIL access_pins: got a=%h rnw=%b we=%h d=%h expected a=%h rnw=%b we=%h d=%h",
                         sram_addr, sram_rnw, sram_we, sram_wdata, a, rnw, rnw ? '0 : be, wd);
            end
        end

        if (en) begin
            if (m_owner_q.size() > 0) begin
                void'(m_owner_q.pop_front());
                void'(m_resp_q.pop_front());
            end
            if (!m_run) begin
                m_clear_cnt++;
                if (m_clear_cnt == DEPTH) begin
                    m_run = 1'b1;
                    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
                end
            end else if (g >= 0) begin
                m_last = g;
                if (rnw) begin
                    m_owner_q.push_back(g);
                    m_resp_q.push_back(ref_mem[a]);
                end else begin
                    for (int l = 0; l < WEW; l++)
                        if (be[l]) ref_mem[a][l*LANE +: LANE] = wd[l*LANE +: LANE];
                end
            end
        end
        m_gnt = g;
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two cycles checking the quiet outputs, then release.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (sram_select !== 1'b0 || req0_ack !== 1'b0 || req1_ack !== 1'b0 ||
                resp0_valid !== 1'b0 || resp1_valid !== 1'b0 || init_done !== 1'b0 ||
                sram_we !== '0 || sram_addr !== '0 || sram_wdata !== '0 || sram_rnw !== 1'b0 ||
                resp0_data !== sram_q) begin
                n_fail++;
                $display("FAIL reset_outputs: got sel=%b ack=%b%b rv=%b%b init=%b expected all 0",
                         sram_select, req0_ack, req1_ack, resp0_valid, resp1_valid, init_done);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    task automatic run_clear(output int cycles);
        cycles = 0;
        while (!m_run && cycles < DEPTH + 4) begin
            cycle();
            cycles++;
        end
        n_checks++;
        if (!m_run) begin
            n_fail++;
            $display("FAIL clear_timeout: got %0d cycles without finishing, required %0d", cycles,
                     DEPTH);
        end
    endtask

    task automatic set_req(input int k, input bit v, input bit rnw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [WEW-1:0] be);
        if (k == 0) begin r0v = v; r0rnw = rnw; r0a = a; r0d = d; r0be = be; end
        else        begin r1v = v; r1rnw = rnw; r1a = a; r1d = d; r1be = be; end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    // Requests held during the sweep must not be acked; first RUN cycle acks.
    task automatic test_clear();
        int c;
        set_req(0, 1'b1, 1'b1, 5'd0, '0, '0);
        run_clear(c);
        n_checks++;
        if (c !== DEPTH) begin
            n_fail++;
            $display("FAIL clear_length: got %0d cycles expected %0d", c, DEPTH);
        end
        cycle();
        n_checks++;
        if (obs_init !== 1'b1 || obs_ack0 !== 1'b1) begin
            n_fail++;
            $display("FAIL first_run_cycle: got init=%b ack0=%b expected 1 1", obs_init, obs_ack0);
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic test_write_read();
        set_req(1, 1'b1, 1'b0, 5'h10, 32'h12345678, 4'hf);
        cycle();
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        set_req(0, 1'b1, 1'b0, 5'h10, 32'hDEADBEEF, 4'b0011);
        cycle();
        set_req(0, 1'b1, 1'b1, 5'h10, '0, '0);
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        cycle();
        n_checks++;
        if (obs_rv0 !== 1'b1 || obs_rd0 !== 32'h1234BEEF) begin
            n_fail++;
            $display("FAIL byte_merge: got v=%b d=%h expected v=1 d=1234beef", obs_rv0, obs_rd0);
        end
    endtask

    task automatic test_alternate();
        int c;
        do_reset();
        run_clear(c);
        set_req(1, 1'b1, 1'b0, 5'd3, 32'hCAFE0003, 4'hf);
        cycle();
        set_req(1, 1'b1, 1'b0, 5'd5, 32'hBEEF0005, 4'hf);
        cycle();
        set_req(0, 1'b1, 1'b1, 5'd3, '0, '0);
        set_req(1, 1'b1, 1'b1, 5'd5, '0, '0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (obs_ack0 !== (i % 2 == 0) || obs_ack1 !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL alternate[%0d]: got %b%b expected %b%b", i, obs_ack0, obs_ack1,
                         i % 2 == 0, i % 2 == 1);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        cycle();
        n_checks++;
        if (obs_rv1 !== 1'b1 || obs_rv0 !== 1'b0) begin
            n_fail++;
            $display("FAIL last_resp_port: got %b%b expected 01", obs_rv0, obs_rv1);
        end
    endtask

    task automatic test_stall();
        set_req(0, 1'b1, 1'b1, 5'd3, '0, '0);
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 1'b1, 5'd5, '0, '0);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (obs_rv0 !== 1'b0 || obs_ack1 !== 1'b0) begin
                n_fail++;
                $display("FAIL stall[%0d]: got rv0=%b ack1=%b expected 0 0", i, obs_rv0, obs_ack1);
            end
        end
        en = 1'b1;
        cycle();
        n_checks++;
        if (obs_rv0 !== 1'b1 || obs_rd0 !== 32'hCAFE0003) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b d=%h expected v=1 d=cafe0003", obs_rv0, obs_rd0);
        end
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic test_reset_mid_clear();
        int c;
        do_reset();
        repeat (7) cycle();
        do_reset();
        cycle();
        n_checks++;
        if (obs_addr !== '0 || obs_init !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_restart: got addr=%h init=%b expected 0 0", obs_addr, obs_init);
        end
        run_clear(c);
        n_checks++;
        if (c !== DEPTH - 1) begin
            n_fail++;
            $display("FAIL restart_length: got %0d expected %0d", c, DEPTH - 1);
        end
    endtask

    task automatic test_reset_after_read();
        int c;
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h0BADF00D, 4'hf);
        set_req(1, 1'b1, 1'b1, 5'd9, '0, '0);
        cycle();
        cycle();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        do_reset();
        run_clear(c);
        set_req(0, 1'b1, 1'b1, 5'd1, '0, '0);
        set_req(1, 1'b1, 1'b1, 5'd2, '0, '0);
        cycle();
        n_checks++;
        if (obs_ack0 !== 1'b1 || obs_ack1 !== 1'b0 || obs_rv0 !== 1'b0 || obs_rv1 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: got ack=%b%b rv=%b%b expected ack=10 rv=00",
                     obs_ack0, obs_ack1, obs_rv0, obs_rv1);
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 4) != 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                if (m_gnt == k || (k == 0 ? !r0v : !r1v)) begin
                    set_req(k, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                            AW'($urandom_range(0, 7)), $urandom, WEW'($urandom));
                end
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        en = 1'b1;
        cycle();
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_clear();
        test_write_read();
        test_alternate();
        test_stall();
        test_reset_mid_clear();
        test_reset_after_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
